hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 13 +
 rtl/forward_unit.sv | 25 ++
 rtl/hazard_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Single-operand EX forwarding select: the MEM result wins over the WB result; x0 is never forwarded.
module forward_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] rd_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       reg_write_m_i,
   input  logic       reg_write_w_i,
   output logic [1:0] fwd_o
);

   // Priority compare against the M and W destination registers
   always_comb begin
      fwd_o = FWD_RF;
      if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
         fwd_o = FWD_MEM;
      end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
         fwd_o = FWD_WB;
      end else begin
         fwd_o = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for the 5-stage core, including the mul/div hold sequencer.
// Defining HAZARD_PERF_CNT_EN adds the StallCnt_o/FlushCnt_o performance counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int MULDIV_LATENCY = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] Rs1D_i,
   input  logic [4:0] Rs2D_i,
   input  logic [4:0] Rs1E_i,
   input  logic [4:0] Rs2E_i,
   input  logic [4:0] RdE_i,
   input  logic [4:0] RdM_i,
   input  logic [4:0] RdW_i,
   input  logic       RegWriteM_i,
   input  logic       RegWriteW_i,
   input  logic       LoadE_i,
   input  logic       PCSrcE_i,
   input  logic       MdStartE_i,
   output logic       StallF_o,
   output logic       StallD_o,
   output logic       StallE_o,
   output logic       FlushD_o,
   output logic       FlushE_o,
   output logic       FlushM_o,
   output logic [1:0] ForwardAE_o,
   output logic [1:0] ForwardBE_o,
   output logic       MdBusy_o,
   output logic       MdDone_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [DATA_WIDTH-1:0] StallCnt_o,
   output logic [DATA_WIDTH-1:0] FlushCnt_o
`endif
);

   localparam int            CW       = $clog2(MULDIV_LATENCY) + 1;
   localparam logic          MD_EN    = (MULDIV_LATENCY > 1);
   localparam logic [CW-1:0] CNT_LOAD = (MULDIV_LATENCY > 1) ? CW'(MULDIV_LATENCY - 2) : CW'(0);

   if ((DATA_WIDTH < 1) || (MULDIV_LATENCY < 1) || (MULDIV_LATENCY > 32)) begin : g_bad_param
      $error("hazard_ctrl: DATA_WIDTH must be >= 1 and MULDIV_LATENCY within 1..32");
   end

   md_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          md_start_s;
   logic          load_use_s;

   forward_unit u_fwd_a (
      .rs_i          (Rs1E_i),
      .rd_m_i        (RdM_i),
      .rd_w_i        (RdW_i),
      .reg_write_m_i (RegWriteM_i),
      .reg_write_w_i (RegWriteW_i),
      .fwd_o         (ForwardAE_o)
   );

   forward_unit u_fwd_b (
      .rs_i          (Rs2E_i),
      .rd_m_i        (RdM_i),
      .rd_w_i        (RdW_i),
      .reg_write_m_i (RegWriteM_i),
      .reg_write_w_i (RegWriteW_i),
      .fwd_o         (ForwardBE_o)
   );

   assign md_start_s = MdStartE_i && MD_EN;
   assign load_use_s = LoadE_i && (RdE_i != 5'd0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

   // Mul/div sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: cnt counts the remaining stalled cycles after the start cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (md_start_s) begin
               state_d = MD_BUSY;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = RUN;
            end
         end
         MD_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Pipeline controls; a held mul/div masks branch and load-use handling, and reset forces them low
   always_comb begin
      StallF_o = 1'b0;
      StallD_o = 1'b0;
      StallE_o = 1'b0;
      FlushD_o = 1'b0;
      FlushE_o = 1'b0;
      FlushM_o = 1'b0;
      MdBusy_o = 1'b0;
      MdDone_o = 1'b0;
      if (!rst_n) begin
         MdBusy_o = 1'b0;
      end else if (state_q == MD_BUSY) begin
         MdBusy_o = 1'b1;
         if (cnt_q != '0) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            FlushM_o = 1'b1;
         end else begin
            MdDone_o = 1'b1;
         end
      end else if (md_start_s) begin
         StallF_o = 1'b1;
         StallD_o = 1'b1;
         StallE_o = 1'b1;
         FlushM_o = 1'b1;
         MdBusy_o = 1'b1;
      end else if (PCSrcE_i) begin
         FlushD_o = 1'b1;
         FlushE_o = 1'b1;
      end else if (load_use_s) begin
         StallF_o = 1'b1;
         StallD_o = 1'b1;
         FlushE_o = 1'b1;
      end else begin
         MdBusy_o = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [DATA_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [DATA_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   // Free-running event counters, wrapping naturally
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallF_o) begin
         stall_cnt_d = stall_cnt_q + DATA_WIDTH'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (FlushE_o) begin
         flush_cnt_d = flush_cnt_q + DATA_WIDTH'(1);
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt_o = stall_cnt_q;
   assign FlushCnt_o = flush_cnt_q;
`endif

endmodule
